// File: rtl/rr_mux32_arbiter.sv
// rr_mux32_arbiter: round-robin owner of a 32:1 one-bit selector's select input.
// The arbiter grants one requester at a time and holds the grant until the
// transfer is done, the requester withdraws, or the hold quota runs out.
// A mandatory GAP cycle follows every release, so grants never overlap.
module rr_mux32_arbiter #(
    parameter int unsigned MAXHOLD = 8,
    parameter int unsigned CW      = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] req,
    input  logic        done,
    output logic [4:0]  sel,
    output logic [31:0] gnt,
    output logic        gnt_valid,
    output logic        timeout
);

    localparam int unsigned N  = 32;
    localparam int unsigned SW = 5;

    // Value the hold counter reaches in the final cycle a grant may be held.
    localparam logic [CW-1:0] CNT_LAST = CW'(MAXHOLD - 1);

    // Reject parameter sets the hold counter cannot represent.
    if (MAXHOLD < 2 || MAXHOLD > 255 || (64'(1) << CW) <= 64'(MAXHOLD)) begin : g_bad_param
        $error("rr_mux32_arbiter: illegal MAXHOLD/CW combination");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [SW-1:0]   ptr;
    logic [SW-1:0]   ptr_nxt;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_nxt;
    logic [SW-1:0]   sel_nxt;
    logic [N-1:0]    gnt_nxt;
    logic            gnt_valid_nxt;
    logic            timeout_nxt;

    logic [SW-1:0]   win_idx;
    logic            win_found;
    logic            rel_done;
    logic            rel_withdraw;
    logic            rel_quota;

    // Winner search: first requester at or after ptr, wrapping modulo 32.
    always_comb begin
        win_idx   = '0;
        win_found = 1'b0;
        for (int unsigned off = 0; off < N; off++) begin
            if (!win_found && req[ptr + SW'(off)]) begin
                win_idx   = ptr + SW'(off);
                win_found = 1'b1;
            end
        end
    end

    // Release causes while BUSY; the earlier term in the list takes priority.
    always_comb begin
        rel_done     = done;
        rel_withdraw = !done && !req[sel];
        rel_quota    = !done && req[sel] && (cnt == CNT_LAST);
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nxt     = state;
        ptr_nxt       = ptr;
        cnt_nxt       = cnt;
        sel_nxt       = sel;
        gnt_nxt       = gnt;
        gnt_valid_nxt = gnt_valid;
        timeout_nxt   = 1'b0;

        unique case (state)
            S_IDLE: begin
                gnt_nxt       = '0;
                gnt_valid_nxt = 1'b0;
                if (win_found) begin
                    state_nxt        = S_BUSY;
                    sel_nxt          = win_idx;
                    gnt_nxt[win_idx] = 1'b1;
                    gnt_valid_nxt    = 1'b1;
                    cnt_nxt          = '0;
                end
            end
            S_BUSY: begin
                if (rel_done || rel_withdraw || rel_quota) begin
                    // sel is left untouched so the selector output stays stable.
                    state_nxt     = S_GAP;
                    gnt_nxt       = '0;
                    gnt_valid_nxt = 1'b0;
                    ptr_nxt       = sel + SW'(1);
                    timeout_nxt   = rel_quota;
                end else if (cnt != CNT_LAST) begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            S_GAP: begin
                state_nxt     = S_IDLE;
                gnt_nxt       = '0;
                gnt_valid_nxt = 1'b0;
            end
            default: begin
                state_nxt     = S_IDLE;
                gnt_nxt       = '0;
                gnt_valid_nxt = 1'b0;
            end
        endcase
    end

    // State, pointer, counter and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            ptr       <= '0;
            cnt       <= '0;
            sel       <= '0;
            gnt       <= '0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            cnt       <= cnt_nxt;
            sel       <= sel_nxt;
            gnt       <= gnt_nxt;
            gnt_valid <= gnt_valid_nxt;
            timeout   <= timeout_nxt;
        end
    end

endmodule

// File: tb/tb_rr_mux32_arbiter.sv
// Bench for rr_mux32_arbiter: grant/release events predicted by a
// transaction-level model are queued and checked by an independent monitor.
module tb_rr_mux32_arbiter;

    localparam int unsigned MAXHOLD = 8;
    localparam int unsigned CW      = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] req;
    logic        done;
    logic [4:0]  sel;
    logic [31:0] gnt;
    logic        gnt_valid;
    logic        timeout;

    rr_mux32_arbiter #(.MAXHOLD(MAXHOLD), .CW(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .done      (done),
        .sel       (sel),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct { int idx; int cyc; } grant_exp_t;
    typedef struct { bit to;  int cyc; } rel_exp_t;
    grant_exp_t gq[$];
    rel_exp_t   rq[$];

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h cyc=%0d", name, act, exp, cyc);
        end
    endfunction

    // Reference model: phase 0 idle, 1 holding, 2 turnaround.
    int m_phase = 0;
    int m_ptr   = 0;
    int m_owner = 0;
    int m_held  = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase = 0;
            m_ptr   = 0;
            m_owner = 0;
            m_held  = 0;
            gq.delete();
            rq.delete();
        end else begin
            case (m_phase)
                0: begin
                    if (req != 32'd0) begin
                        int w;
                        w = -1;
                        for (int o = 0; o < 32; o++)
                            if (w < 0 && req[(m_ptr + o) % 32]) w = (m_ptr + o) % 32;
                        gq.push_back('{idx: w, cyc: cyc + 1});
                        m_owner = w;
                        m_held  = 1;
                        m_phase = 1;
                    end
                end
                1: begin
                    if (done || !req[m_owner] || m_held == MAXHOLD) begin
                        rq.push_back('{to: (!done && req[m_owner]), cyc: cyc + 1});
                        m_ptr   = (m_owner + 1) % 32;
                        m_phase = 2;
                    end else begin
                        m_held++;
                    end
                end
                default: m_phase = 0;
            endcase
        end
    end

    // Monitor: invariants every cycle, queued expectations on grant edges.
    bit       prev_gv  = 1'b0;
    bit [4:0] prev_sel = 5'd0;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            chk("reset_outputs", {gnt, 5'(sel), gnt_valid, timeout}, 64'd0);
            prev_gv  = 1'b0;
            prev_sel = 5'd0;
        end else begin
            bit exp_to;
            exp_to = 1'b0;
            chk("gnt_onehot0", 64'($onehot0(gnt)), 64'd1);
            chk("gnt_valid_consistent", 64'(gnt_valid), 64'(gnt != 32'd0));
            if (gnt_valid) chk("gnt_at_sel", 64'(gnt[sel]), 64'd1);
            if (!gnt_valid) chk("sel_hold", 64'(sel), 64'(prev_sel));
            if (gnt_valid && !prev_gv) begin
                chk("grant_expected", 64'(gq.size() != 0), 64'd1);
                if (gq.size() != 0) begin
                    grant_exp_t e;
                    e = gq.pop_front();
                    chk("grant_sel", 64'(sel), 64'(e.idx));
                    chk("grant_cycle", 64'(cyc), 64'(e.cyc));
                end
            end
            if (!gnt_valid && prev_gv) begin
                chk("release_expected", 64'(rq.size() != 0), 64'd1);
                if (rq.size() != 0) begin
                    rel_exp_t r;
                    r = rq.pop_front();
                    exp_to = r.to;
                    chk("release_cycle", 64'(cyc), 64'(r.cyc));
                end
            end
            chk("timeout", 64'(timeout), 64'(exp_to));
            prev_gv  = gnt_valid;
            prev_sel = sel;
        end
    end

    // Inputs change 2 time units after the rising edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_gv(input string name);
        int n;
        n = 0;
        while (!gnt_valid && n < 80) begin
            step();
            n++;
        end
        if (!gnt_valid) chk({name, "_grant_timeout"}, 64'(gnt_valid), 64'd1);
    endtask

    task automatic drain();
        req  = 32'd0;
        done = 1'b0;
        repeat (14) step();
    endtask

    initial begin
        rst  = 1'b1;
        req  = 32'hFFFF_FFFF;
        done = 1'b0;
        repeat (2) step();
        rst = 1'b0;

        // Sweep: everyone requesting, done two cycles into each grant.
        for (int g = 0; g < 34; g++) begin
            wait_gv("sweep");
            step();
            done = 1'b1;
            step();
            done = 1'b0;
        end

        // Quota expiry on a lone requester, then re-grant to it.
        drain();
        req = 32'h0000_0008;
        repeat (30) step();

        // Grant to 5, then withdraw while bits 0 and 4 appear: pointer 6 wraps to 0.
        drain();
        req = 32'h0000_0020;
        wait_gv("prio");
        step();
        req = 32'h0000_0011;
        repeat (8) step();

        // Mid-grant withdrawal by requester 7.
        drain();
        req = 32'h0000_0080;
        wait_gv("withdraw");
        repeat (2) step();
        req = 32'd0;
        repeat (5) step();

        // done and quota expiry on the same edge.
        drain();
        req = 32'h0000_0200;
        wait_gv("simul");
        repeat (7) step();
        done = 1'b1;
        step();
        done = 1'b0;
        req  = 32'd0;
        repeat (5) step();

        // Randomized traffic with sparse requests and random done pulses.
        drain();
        for (int c = 0; c < 700; c++) begin
            if ($urandom_range(0, 7) == 0) begin
                case ($urandom_range(0, 3))
                    0: req = $urandom() & $urandom() & $urandom();
                    1: req = 32'd1 << $urandom_range(0, 31);
                    2: req = $urandom();
                    default: req = 32'd0;
                endcase
            end
            done = ($urandom_range(0, 5) == 0);
            step();
        end

        // Asynchronous reset while granted to 12.
        drain();
        req = 32'h0000_1000;
        wait_gv("areset");
        step();
        rst = 1'b1;
        #1;
        chk("areset_gnt", 64'(gnt), 64'd0);
        chk("areset_gnt_valid", 64'(gnt_valid), 64'd0);
        chk("areset_sel", 64'(sel), 64'd0);
        chk("areset_timeout", 64'(timeout), 64'd0);
        step();
        req = 32'hFFFF_FFFF;
        rst = 1'b0;
        for (int g = 0; g < 3; g++) begin
            wait_gv("post_reset");
            step();
            done = 1'b1;
            step();
            done = 1'b0;
        end

        drain();
        chk("grant_queue_empty", 64'(gq.size()), 64'd0);
        chk("release_queue_empty", 64'(rq.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
